// File: rtl/logic_gate_pkg.sv
// Op codes and the per-bit 3-input gate function shared by the logic_gate_pipe datapath.
package logic_gate_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND3  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR3   = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR3  = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND3 = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR3  = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR3 = 3'd5;
  localparam logic [OP_W-1:0] OP_MUX   = 3'd6;
  localparam logic [OP_W-1:0] OP_MAJ   = 3'd7;

  // Evaluated one bit at a time so the caller can apply it to any operand width.
  function automatic logic gate_eval(input logic [OP_W-1:0] op,
                                     input logic a, input logic b, input logic c);
    logic r;
    r = 1'b0;
    case (op)
      OP_AND3:  r = a & b & c;
      OP_OR3:   r = a | b | c;
      OP_XOR3:  r = a ^ b ^ c;
      OP_NAND3: r = ~(a & b & c);
      OP_NOR3:  r = ~(a | b | c);
      OP_XNOR3: r = ~(a ^ b ^ c);
      OP_MUX:   r = c ? b : a;
      OP_MAJ:   r = (a & b) | (a & c) | (b & c);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_gate_stage.sv
// One valid/ready register slice; loads whenever it is empty or its contents leave this cycle,
// so an empty slice absorbs data even while everything downstream is stalled.
module logic_gate_stage #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             vld;
  logic [WIDTH-1:0] data;

  assign in_ready  = ~vld | out_ready;
  assign out_valid = vld;
  assign out_data  = data;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld  <= 1'b0;
      data <= '0;
    end else if (in_ready) begin
      vld <= in_valid;
      if (in_valid) data <= in_data;
    end
  end

endmodule

// File: rtl/logic_gate_pipe.sv
// Pipelined 3-input bitwise gate with valid/ready flow control and bubble collapsing.
// Build option LOGIC_GATE_PIPE_STATS_EN adds the xfer_count / stall_flag statistics outputs.
module logic_gate_pipe
  import logic_gate_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_parity
`ifdef LOGIC_GATE_PIPE_STATS_EN
  ,
  output logic [15:0]      xfer_count,
  output logic             stall_flag
`endif
);

  localparam int PW = WIDTH + 1;

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("logic_gate_pipe: STAGES must be in 1..4");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("logic_gate_pipe: WIDTH must be at least 1");
  end

  logic [WIDTH-1:0] f_res;
  logic             f_par;

  always_comb begin
    f_res = '0;
    for (int i = 0; i < WIDTH; i++) begin
      f_res[i] = gate_eval(op, a[i], b[i], c[i]);
    end
    f_par = ^f_res;
  end

  // Each slice keeps its own handshake nets so the ready chain never loops through one vector.
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic          up_valid;
    logic          up_ready;
    logic [PW-1:0] up_data;
    logic          dn_valid;
    logic          dn_ready;
    logic [PW-1:0] dn_data;

    if (i == 0) begin : g_first
      assign up_valid = in_valid;
      assign up_data  = {f_par, f_res};
    end else begin : g_next
      assign up_valid = g_stage[i-1].dn_valid;
      assign up_data  = g_stage[i-1].dn_data;
    end

    if (i == STAGES - 1) begin : g_last
      assign dn_ready = out_ready;
    end else begin : g_mid
      assign dn_ready = g_stage[i+1].up_ready;
    end

    logic_gate_stage #(.WIDTH(PW)) u_stage (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (up_valid),
      .in_ready  (up_ready),
      .in_data   (up_data),
      .out_valid (dn_valid),
      .out_ready (dn_ready),
      .out_data  (dn_data)
    );
  end

  assign in_ready        = g_stage[0].up_ready;
  assign out_valid       = g_stage[STAGES-1].dn_valid;
  assign {y_parity, y}   = g_stage[STAGES-1].dn_data;

`ifdef LOGIC_GATE_PIPE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      xfer_count <= '0;
      stall_flag <= 1'b0;
    end else begin
      if (out_valid && out_ready && xfer_count != 16'hFFFF) begin
        xfer_count <= xfer_count + 16'd1;
      end
      stall_flag <= out_valid & ~out_ready;
    end
  end
`endif

endmodule
